// File: rtl/cache_nway_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_nway_if
// Description : CPU-side line bus and memory-side fill/writeback bus of the
//               N-way cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_nway_if;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_byte_enable;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  // Cache side
  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  // CPU and memory side
  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface
`default_nettype wire

// File: rtl/cache_nway.sv
`default_nettype none
// ============================================================================
// Module      : cache_nway
// Description : N-way set-associative write-back, write-allocate cache with
//               tree pseudo-LRU replacement and an integrated controller.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_nway #(
  parameter int WAYS     = 4,
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  cache_nway_if.slave   bus
);

  localparam int S_TAG = 32 - S_OFFSET - S_INDEX;
  localparam int SETS  = 2 ** S_INDEX;
  localparam int WB    = $clog2(WAYS);
  localparam int NODES = WAYS - 1;

  localparam logic [1:0] C_IDLE      = 2'd0;
  localparam logic [1:0] C_WRITEBACK = 2'd1;
  localparam logic [1:0] C_FILL      = 2'd2;

  logic [1:0]         r_state;
  logic [WB-1:0]      r_victim;
  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAYS-1:0]    r_dirty [SETS];
  logic [NODES-1:0]   r_plru  [SETS];
  logic [S_TAG-1:0]   r_tag   [SETS][WAYS];
  logic [255:0]       r_data  [SETS][WAYS];

  logic [S_INDEX-1:0] w_set;
  logic [S_TAG-1:0]   w_tag;
  logic               w_req;
  logic               w_idle;
  logic               w_hit;
  logic [WAYS-1:0]    w_hit_vec;
  logic [WB-1:0]      w_hit_way;
  logic [WB-1:0]      w_victim;
  logic [NODES-1:0]   w_plru_next;
  logic               w_unused_offset;

  assign w_set  = bus.mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign w_tag  = bus.mem_address[31:S_OFFSET+S_INDEX];
  assign w_req  = bus.mem_read | bus.mem_write;
  assign w_idle = (r_state == C_IDLE);
  assign w_hit  = |w_hit_vec;
  assign w_unused_offset = &{1'b0, bus.mem_address[S_OFFSET-1:0]};

  for (genvar g = 0; g < WAYS; g++) begin : g_hit
    assign w_hit_vec[g] = r_valid[w_set][g] && (r_tag[w_set][g] == w_tag);
  end

  always_comb begin
    w_hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (w_hit_vec[i]) w_hit_way = w_hit_way | WB'(i);
    end
  end

  // Lowest invalid way wins; otherwise walk the PLRU tree from the root.
  always_comb begin
    int  node;
    logic inv_found;
    logic [WB-1:0] inv_way;
    node      = 0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!r_valid[w_set][i]) begin
        inv_found = 1'b1;
        inv_way   = WB'(i);
      end
    end
    for (int l = 0; l < WB; l++) begin
      node = 2 * node + 1 + int'(r_plru[w_set][node]);
    end
    w_victim = inv_found ? inv_way : WB'(node - NODES);
  end

  // Point every node on the hit way's path away from it.
  always_comb begin
    int   unode;
    logic dir;
    unode       = 0;
    dir         = 1'b0;
    w_plru_next = r_plru[w_set];
    for (int l = 0; l < WB; l++) begin
      dir                = w_hit_way[WB-1-l];
      w_plru_next[unode] = ~dir;
      unode              = 2 * unode + 1 + int'(dir);
    end
  end

  assign bus.mem_resp   = w_idle & w_req & w_hit;
  assign bus.mem_rdata  = r_data[w_set][w_hit_way];
  assign bus.pmem_write = (r_state == C_WRITEBACK);
  assign bus.pmem_read  = (r_state == C_FILL);

  always_comb begin
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    if (r_state == C_WRITEBACK) begin
      bus.pmem_address = {r_tag[w_set][r_victim], w_set, {S_OFFSET{1'b0}}};
      bus.pmem_wdata   = r_data[w_set][r_victim];
    end else if (r_state == C_FILL) begin
      bus.pmem_address = {w_tag, w_set, {S_OFFSET{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
      r_state  <= C_IDLE;
      r_victim <= '0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              r_plru[w_set] <= w_plru_next;
              if (bus.mem_write) r_dirty[w_set][w_hit_way] <= 1'b1;
            end else begin
              r_victim <= w_victim;
              r_state  <= (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim])
                          ? C_WRITEBACK : C_FILL;
            end
          end
        end
        C_WRITEBACK: begin
          if (bus.pmem_resp) begin
            r_dirty[w_set][r_victim] <= 1'b0;
            r_state                  <= C_FILL;
          end
        end
        C_FILL: begin
          if (bus.pmem_resp) begin
            r_valid[w_set][r_victim] <= 1'b1;
            r_dirty[w_set][r_victim] <= 1'b0;
            r_state                  <= C_IDLE;
          end
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_idle && w_req && w_hit && bus.mem_write) begin
      for (int b = 0; b < 32; b++) begin
        if (bus.mem_byte_enable[b])
          r_data[w_set][w_hit_way][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
    if ((r_state == C_FILL) && bus.pmem_resp) begin
      r_data[w_set][r_victim] <= bus.pmem_rdata;
      r_tag[w_set][r_victim]  <= w_tag;
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_hit_vec));

endmodule
`default_nettype wire

// File: tb/tb_cache_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_nway
// Description : Scoreboard bench for cache_nway (4-way/8-set and 8-way/4-set)
//               against a flat-memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_nway;
  typedef struct packed { logic wr; logic [31:0] addr; } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_addr, cpu_be;
  logic [255:0] cpu_wdata, rdata_drv;
  logic         mem_resp_drv;

  cache_nway_if bus4();
  cache_nway_if bus8();

  cache_nway #(.WAYS(4), .S_OFFSET(5), .S_INDEX(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  cache_nway #(.WAYS(8), .S_OFFSET(5), .S_INDEX(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  assign bus4.mem_read        = cpu_read & ~sel;
  assign bus4.mem_write       = cpu_write & ~sel;
  assign bus4.mem_address     = cpu_addr;
  assign bus4.mem_wdata       = cpu_wdata;
  assign bus4.mem_byte_enable = cpu_be;
  assign bus4.pmem_rdata      = rdata_drv;
  assign bus4.pmem_resp       = mem_resp_drv & ~sel;
  assign bus8.mem_read        = cpu_read & sel;
  assign bus8.mem_write       = cpu_write & sel;
  assign bus8.mem_address     = cpu_addr;
  assign bus8.mem_wdata       = cpu_wdata;
  assign bus8.mem_byte_enable = cpu_be;
  assign bus8.pmem_rdata      = rdata_drv;
  assign bus8.pmem_resp       = mem_resp_drv & sel;

  logic         v_resp, v_pread, v_pwrite;
  logic [255:0] v_rdata, v_pwdata;
  logic [31:0]  v_paddr;
  assign v_resp   = sel ? bus8.mem_resp     : bus4.mem_resp;
  assign v_rdata  = sel ? bus8.mem_rdata    : bus4.mem_rdata;
  assign v_pread  = sel ? bus8.pmem_read    : bus4.pmem_read;
  assign v_pwrite = sel ? bus8.pmem_write   : bus4.pmem_write;
  assign v_paddr  = sel ? bus8.pmem_address : bus4.pmem_address;
  assign v_pwdata = sel ? bus8.pmem_wdata   : bus4.pmem_wdata;

  // Reference: backing memory plus the architectural value of every line.
  logic [255:0] mem_m [logic [31:0]];
  logic [255:0] gold  [logic [31:0]];
  logic [255:0] exp_q [$];
  txn_t         txn_q [$];
  int errors = 0;
  int checks = 0;
  int mem_lat = 3;
  bit rnd_lat = 1'b0;

  function automatic logic [255:0] line_init(input logic [31:0] a);
    logic [255:0] l;
    if (a == 32'h40) return {32{8'hA5}};
    for (int i = 0; i < 8; i++) l[32*i +: 32] = (a * 32'(i + 1)) ^ 32'h5A5A_1234;
    return l;
  endfunction

  function automatic logic [255:0] mem_get(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : line_init(a);
  endfunction

  function automatic logic [255:0] gold_get(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : mem_get(a);
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] wd,
                                         input logic [31:0] be);
    logic [255:0] r;
    r = old;
    for (int i = 0; i < 32; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_txn(input string name, input logic wr, input logic [31:0] addr);
    txn_t t;
    checks++;
    if (txn_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no memory transaction, expected wr=%0d addr=%h", name, wr, addr);
    end else begin
      t = txn_q.pop_front();
      if (t.wr !== wr || t.addr !== addr) begin
        errors++;
        $display("FAIL %s: got wr=%0d addr=%h, expected wr=%0d addr=%h", name, t.wr, t.addr, wr, addr);
      end
    end
  endtask

  // Memory responder: answers each pmem request after a latency.
  initial begin : p_memory
    int cnt;
    int cur_lat;
    cnt = 0;
    cur_lat = 3;
    mem_resp_drv = 1'b0;
    rdata_drv = '0;
    forever begin
      @(negedge clk);
      mem_resp_drv = 1'b0;
      if (rst_n && (v_pread || v_pwrite)) begin
        if (cnt == 0) cur_lat = rnd_lat ? int'($urandom_range(1, 4)) : mem_lat;
        cnt++;
        if (cnt >= cur_lat) begin
          cnt = 0;
          checks++;
          if (v_paddr[4:0] != 5'd0) begin
            errors++;
            $display("FAIL pmem_align: got addr %h, expected low 5 bits zero", v_paddr);
          end
          if (v_pwrite) begin
            checks++;
            if (v_pwdata !== gold_get(v_paddr)) begin
              errors++;
              $display("FAIL writeback_data @%h: got %h expected %h", v_paddr, v_pwdata, gold_get(v_paddr));
            end
            mem_m[v_paddr] = v_pwdata;
            txn_q.push_back({1'b1, v_paddr});
          end else begin
            rdata_drv = mem_get(v_paddr);
            txn_q.push_back({1'b0, v_paddr});
          end
          mem_resp_drv = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every mem_resp retires the oldest expected line.
  initial begin : p_monitor
    logic [255:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && v_resp) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp: got unexpected mem_resp, expected none outstanding");
        end else begin
          e = exp_q.pop_front();
          if (v_rdata !== e) begin
            errors++;
            $display("FAIL rdata: got %h expected %h", v_rdata, e);
          end
        end
      end
    end
  end

  task automatic access(input bit wr, input logic [31:0] a, input logic [255:0] wd,
                        input logic [31:0] be, output int lat);
    logic [31:0] la;
    bit done;
    la = a & ~32'h1f;
    done = 1'b0;
    @(negedge clk);
    cpu_read = !wr;
    cpu_write = wr;
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_be = be;
    exp_q.push_back(gold_get(la));
    if (wr) gold[la] = merge(gold_get(la), wd, be);
    lat = 0;
    while (!done) begin
      #3;
      if (v_resp) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
        if (lat > 60) begin
          errors++;
          $display("FAIL timeout @%h: got no mem_resp after %0d cycles, expected a response", a, lat);
          finish_run();
        end
      end
    end
    @(negedge clk);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic do_reset(input bit s);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    sel = s;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    mem_m.delete();
    gold.delete();
    txn_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int n);
    int lat;
    bit wr;
    logic [31:0] a, be;
    logic [255:0] wd;
    rnd_lat = 1'b1;
    repeat (n) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 11) << 9) | ($urandom_range(0, 1) << 5) | $urandom_range(0, 31);
      for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom();
      be = $urandom();
      access(wr, a, wd, be, lat);
    end
    rnd_lat = 1'b0;
    txn_q.delete();
  endtask

  int lat;
  logic [31:0] a8;
  int hit_order [7] = '{2, 3, 4, 5, 6, 7, 1};

  initial begin : p_main
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    cpu_be = '0;
    #1;
    check_int("reset mem_resp", int'(v_resp), 0);
    check_int("reset pmem_read", int'(v_pread), 0);
    check_int("reset pmem_write", int'(v_pwrite), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 4-way, 8 sets: cold miss, hits, byte-enable write, fills, evictions
    access(0, 32'h40, '0, '0, lat);
    check_int("cold miss latency", lat, 4);
    check_txn("cold fill", 1'b0, 32'h40);
    check_int("cold miss single txn", txn_q.size(), 0);
    access(0, 32'h40, '0, '0, lat);
    check_int("read hit latency", lat, 0);
    access(1, 32'h44, '1, 32'h0000_000F, lat);
    check_int("write hit latency", lat, 0);
    access(0, 32'h40, '0, '0, lat);
    check_int("read after write latency", lat, 0);
    for (int k = 1; k < 4; k++) begin
      access(0, 32'h40 + 32'(k) * 32'h100, '0, '0, lat);
      check_int("invalid-way fill latency", lat, 4);
      check_txn("invalid-way fill", 1'b0, 32'h40 + 32'(k) * 32'h100);
    end
    access(0, 32'h440, '0, '0, lat);
    check_int("dirty miss latency", lat, 7);
    check_txn("dirty victim writeback", 1'b1, 32'h40);
    check_txn("fill after writeback", 1'b0, 32'h440);
    access(0, 32'h540, '0, '0, lat);
    check_int("plru clean miss latency", lat, 4);
    check_txn("plru evicts way2", 1'b0, 32'h540);
    check_int("clean victim no writeback", txn_q.size(), 0);
    access(0, 32'h140, '0, '0, lat);
    check_int("survivor 0x140 hits", lat, 0);
    access(0, 32'h240, '0, '0, lat);
    check_int("evicted 0x240 misses", lat, 4);
    check_txn("refill 0x240", 1'b0, 32'h240);
    access(0, 32'h440, '0, '0, lat);
    check_int("0x440 still cached", lat, 0);

    // Reset while a fill is outstanding
    @(negedge clk);
    cpu_read = 1'b1;
    cpu_addr = 32'h640;
    for (int i = 0; i < 10 && !v_pread; i++) @(negedge clk);
    check_int("fill started before reset", int'(v_pread), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_int("async reset drops pmem_read", int'(v_pread), 0);
    cpu_read = 1'b0;
    gold = mem_m;
    txn_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 32'h140, '0, '0, lat);
    check_int("0x140 misses after reset", lat, 4);
    check_txn("refill 0x140 after reset", 1'b0, 32'h140);

    random_phase(250);

    // 8-way, 4 sets: nine tags into set 1
    do_reset(1'b1);
    for (int k = 0; k < 9; k++) begin
      a8 = 32'h20 + 32'(k) * 32'h80;
      access(0, a8, '0, '0, lat);
      check_int("8-way fill latency", lat, 4);
      check_txn("8-way fill", 1'b0, a8);
    end
    check_int("8-way no writebacks", txn_q.size(), 0);
    for (int j = 0; j < 7; j++) begin
      access(0, 32'h20 + 32'(hit_order[j]) * 32'h80, '0, '0, lat);
      check_int("8-way survivors hit", lat, 0);
    end
    access(0, 32'h20, '0, '0, lat);
    check_int("8-way way0 was evicted", lat, 4);
    check_txn("8-way refill 0x20", 1'b0, 32'h20);

    random_phase(250);

    @(negedge clk);
    #3;
    check_int("scoreboard drained", exp_q.size(), 0);
    finish_run();
  end
endmodule
`default_nettype wire
